drm_data2_port_arb: RTL and testbench

Two-requester port arbiter and sequencer for the 1024 x 8 simple dual-port block RAM (drm_data2, no output register, byte-enable write). It accepts read/write commands from two clients, grants at most one write and one read per cycle using independent round-robin arbiters, drives registered RAM port signals, and returns read data to the issuing client. The RAM read clock is tied to wr_clk, so the whole block is single-clock.

---
 rtl/drm_data2_pkg.sv | 26 ++
 rtl/drm_data2_port_arb_if.sv | 33 +++
 rtl/drm_data2_rr2.sv | 45 ++++
 rtl/drm_data2_port_arb.sv | 139 +++++++++++++
 tb/tb_drm_data2_port_arb.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drm_data2_pkg.sv
// Shared types and defaults for the drm_data2 port arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package drm_data2_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

  // Client identifier: 0 or 1.
  typedef logic client_id_t;

  // One client command as seen at the arbiter boundary.
  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_BE_WIDTH-1:0]   be;
  } cmd_t;

  // The client that gets priority after the given one was served.
  function automatic client_id_t other_client(input client_id_t id);
    return client_id_t'(~id);
  endfunction

endpackage

// File: rtl/drm_data2_port_arb_if.sv
// Per-client command/response bundle between one client and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready on commands; responses have no backpressure.
interface drm_data2_port_arb_if
  import drm_data2_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DEF_BE_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Client side drives commands and receives responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side accepts commands and returns responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/drm_data2_rr2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// Latency: grant is combinational; pointer updates on the edge when advance is high.
// Backpressure: caller withholds advance to keep the pointer unchanged.
module drm_data2_rr2
  import drm_data2_pkg::*;
(
  input  logic       wr_clk,
  input  logic       tb_wr_rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  client_id_t prio_q;
  client_id_t prio_d;

  // Grant the lone requester, or the priority holder when both request.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_q == 1'b1) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a served grant the other client becomes the priority holder.
  always_comb begin
    prio_d = prio_q;
    if (advance && (gnt != 2'b00)) begin
      prio_d = other_client(client_id_t'(gnt[1]));
    end
  end

  // Pointer register; client 0 holds priority out of reset.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/drm_data2_port_arb.sv
// Two-client arbiter/sequencer for the drm_data2 1024x8 dual-port RAM.
// Latency: RAM ports registered 1 cycle after handshake; read data 2 cycles after handshake.
// Backpressure: combinational req_ready per client; read stalls on same-cycle write address hit.
module drm_data2_port_arb
  import drm_data2_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DEF_BE_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  drm_data2_port_arb_if.slave   c0,
  drm_data2_port_arb_if.slave   c1,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic [1:0]            wr_req;
  logic [1:0]            rd_req;
  logic [1:0]            wr_gnt;
  logic [1:0]            rd_gnt_raw;
  logic [1:0]            rd_gnt;
  logic                  collision;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [BE_WIDTH-1:0]   wr_be_sel;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;

  logic                  ram_wr_en_q,      ram_wr_en_d;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q,    ram_wr_addr_d;
  logic [DATA_WIDTH-1:0] ram_wr_data_q,    ram_wr_data_d;
  logic [BE_WIDTH-1:0]   ram_wr_byte_en_q, ram_wr_byte_en_d;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_q,    ram_rd_addr_d;
  // Read tag pipeline: stage 1 tracks the RAM sampling cycle, stage 2 the data cycle.
  logic                  tag1_vld_q, tag1_vld_d;
  client_id_t            tag1_id_q,  tag1_id_d;
  logic                  tag2_vld_q, tag2_vld_d;
  client_id_t            tag2_id_q,  tag2_id_d;

  // Split each client's single command into write and read candidates.
  always_comb begin
    wr_req = {c1.req_valid &  c1.req_we, c0.req_valid &  c0.req_we};
    rd_req = {c1.req_valid & ~c1.req_we, c0.req_valid & ~c0.req_we};
  end

  drm_data2_rr2 u_wr_arb (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .req       (wr_req),
    .advance   (1'b1),
    .gnt       (wr_gnt)
  );

  // A read stalled by a collision must not move its pointer.
  drm_data2_rr2 u_rd_arb (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .req       (rd_req),
    .advance   (~collision),
    .gnt       (rd_gnt_raw)
  );

  // Mux granted commands and drop a read that hits this cycle's write address.
  always_comb begin
    wr_addr_sel = wr_gnt[1] ? c1.req_addr  : c0.req_addr;
    wr_data_sel = wr_gnt[1] ? c1.req_wdata : c0.req_wdata;
    wr_be_sel   = wr_gnt[1] ? c1.req_be    : c0.req_be;
    rd_addr_sel = rd_gnt_raw[1] ? c1.req_addr : c0.req_addr;
    collision   = (wr_gnt != 2'b00) && (rd_gnt_raw != 2'b00) && (wr_addr_sel == rd_addr_sel);
    rd_gnt      = collision ? 2'b00 : rd_gnt_raw;
    c0.req_ready = ~tb_wr_rst & (wr_gnt[0] | rd_gnt[0]);
    c1.req_ready = ~tb_wr_rst & (wr_gnt[1] | rd_gnt[1]);
  end

  // Next-state for RAM port registers and read tag pipeline.
  always_comb begin
    ram_wr_en_d      = (wr_gnt != 2'b00);
    ram_wr_addr_d    = ram_wr_addr_q;
    ram_wr_data_d    = ram_wr_data_q;
    ram_wr_byte_en_d = ram_wr_byte_en_q;
    ram_rd_addr_d    = ram_rd_addr_q;
    if (wr_gnt != 2'b00) begin
      ram_wr_addr_d    = wr_addr_sel;
      ram_wr_data_d    = wr_data_sel;
      ram_wr_byte_en_d = wr_be_sel;
    end
    if (rd_gnt != 2'b00) begin
      ram_rd_addr_d = rd_addr_sel;
    end
    tag1_vld_d = (rd_gnt != 2'b00);
    tag1_id_d  = client_id_t'(rd_gnt[1]);
    tag2_vld_d = tag1_vld_q;
    tag2_id_d  = tag1_id_q;
  end

  // All state clears on reset, which also discards in-flight read tags.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      ram_wr_en_q      <= 1'b0;
      ram_wr_addr_q    <= '0;
      ram_wr_data_q    <= '0;
      ram_wr_byte_en_q <= '0;
      ram_rd_addr_q    <= '0;
      tag1_vld_q       <= 1'b0;
      tag1_id_q        <= 1'b0;
      tag2_vld_q       <= 1'b0;
      tag2_id_q        <= 1'b0;
    end else begin
      ram_wr_en_q      <= ram_wr_en_d;
      ram_wr_addr_q    <= ram_wr_addr_d;
      ram_wr_data_q    <= ram_wr_data_d;
      ram_wr_byte_en_q <= ram_wr_byte_en_d;
      ram_rd_addr_q    <= ram_rd_addr_d;
      tag1_vld_q       <= tag1_vld_d;
      tag1_id_q        <= tag1_id_d;
      tag2_vld_q       <= tag2_vld_d;
      tag2_id_q        <= tag2_id_d;
    end
  end

  // Drive RAM ports and steer the unregistered RAM output to the tagged client.
  always_comb begin
    ram_wr_en      = ram_wr_en_q;
    ram_wr_addr    = ram_wr_addr_q;
    ram_wr_data    = ram_wr_data_q;
    ram_wr_byte_en = ram_wr_byte_en_q;
    ram_rd_addr    = ram_rd_addr_q;
    c0.rsp_valid   = tag2_vld_q & (tag2_id_q == 1'b0);
    c1.rsp_valid   = tag2_vld_q & (tag2_id_q == 1'b1);
    c0.rsp_data    = c0.rsp_valid ? ram_rd_data : '0;
    c1.rsp_data    = c1.rsp_valid ? ram_rd_data : '0;
  end

endmodule

// File: tb/tb_drm_data2_port_arb.sv
// Directed bench for drm_data2_port_arb with a behavioural 1024x8 RAM.
// Latency: expects read data 2 cycles after handshake.
// Backpressure: clients hold commands until req_ready.
module tb_drm_data2_port_arb;

  logic       wr_clk;
  logic       tb_wr_rst;
  logic       ram_wr_en;
  logic [9:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic [0:0] ram_wr_byte_en;
  logic [9:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic [7:0] mem [1024];

  int total;
  int bad;

  drm_data2_port_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .BE_WIDTH(1)) c0_if ();
  drm_data2_port_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .BE_WIDTH(1)) c1_if ();

  drm_data2_port_arb dut (
    .wr_clk         (wr_clk),
    .tb_wr_rst      (tb_wr_rst),
    .c0             (c0_if),
    .c1             (c1_if),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_addr    (ram_wr_addr),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_byte_en (ram_wr_byte_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (ram_rd_data)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  // RAM with registered read, no output register, byte-enable write.
  always @(posedge wr_clk) begin
    if (ram_wr_en && ram_wr_byte_en[0]) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc_start();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic cyc_check();
    @(negedge wr_clk);
  endtask

  task automatic drive_c0(input logic v, input logic we, input logic [9:0] a, input logic [7:0] d, input logic be);
    c0_if.req_valid = v; c0_if.req_we = we; c0_if.req_addr = a; c0_if.req_wdata = d; c0_if.req_be = be;
  endtask

  task automatic drive_c1(input logic v, input logic we, input logic [9:0] a, input logic [7:0] d, input logic be);
    c1_if.req_valid = v; c1_if.req_we = we; c1_if.req_addr = a; c1_if.req_wdata = d; c1_if.req_be = be;
  endtask

  task automatic apply_reset();
    cyc_start();
    tb_wr_rst = 1'b1;
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_start();
    cyc_start();
    tb_wr_rst = 1'b0;
  endtask

  task automatic test_reset();
    tb_wr_rst = 1'b1;
    drive_c0(1'b1, 1'b1, 10'd3, 8'h11, 1'b1);
    drive_c1(1'b1, 1'b0, 10'd4, 8'h22, 1'b1);
    cyc_start();
    cyc_check();
    total++; if (c0_if.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%0b exp=0", c0_if.req_ready); end
    total++; if (c1_if.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%0b exp=0", c1_if.req_ready); end
    total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0b exp=0", ram_wr_en); end
    total++; if (ram_wr_addr !== 10'd0 || ram_wr_data !== 8'd0 || ram_wr_byte_en !== 1'b0 || ram_rd_addr !== 10'd0) begin
      bad++; $display("FAIL rst_ram_ports got=%0h/%0h/%0h/%0h exp=0/0/0/0", ram_wr_addr, ram_wr_data, ram_wr_byte_en, ram_rd_addr);
    end
    total++; if (c0_if.rsp_valid !== 1'b0 || c1_if.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rsp got=%0b%0b exp=00", c0_if.rsp_valid, c1_if.rsp_valid);
    end
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_start();
    tb_wr_rst = 1'b0;
  endtask

  task automatic test_fill_and_readback();
    for (int i = 0; i < 1024; i++) begin
      cyc_start();
      drive_c0(1'b1, 1'b1, 10'(i), 8'(1023 - i), 1'b1);
      cyc_check();
      total++; if (c0_if.req_ready !== 1'b1) begin bad++; $display("FAIL fill_ready i=%0d got=%0b exp=1", i, c0_if.req_ready); end
      if (i > 0) begin
        total++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 10'(i - 1)) begin
          bad++; $display("FAIL fill_port i=%0d got=%0b/%0h exp=1/%0h", i, ram_wr_en, ram_wr_addr, 10'(i - 1));
        end
      end
    end
    for (int i = 0; i < 1026; i++) begin
      cyc_start();
      if (i < 1024) drive_c0(1'b1, 1'b0, 10'(i), 8'd0, 1'b0);
      else          drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
      cyc_check();
      if (i < 1024) begin
        total++; if (c0_if.req_ready !== 1'b1) begin bad++; $display("FAIL read_ready i=%0d got=%0b exp=1", i, c0_if.req_ready); end
      end
      if (i >= 2) begin
        total++; if (c0_if.rsp_valid !== 1'b1 || c0_if.rsp_data !== 8'(1023 - (i - 2))) begin
          bad++; $display("FAIL read_rsp addr=%0d got=%0b/%0h exp=1/%0h", i - 2, c0_if.rsp_valid, c0_if.rsp_data, 8'(1023 - (i - 2)));
        end
      end else begin
        total++; if (c0_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL read_early_rsp i=%0d got=%0b exp=0", i, c0_if.rsp_valid); end
      end
      total++; if (c1_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL read_rsp1 i=%0d got=%0b exp=0", i, c1_if.rsp_valid); end
    end
  endtask

  task automatic test_both_write();
    int idx0 = 0;
    int idx1 = 0;
    logic [9:0] exp_addr = '0;
    logic [9:0] a0, a1;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      cyc_start();
      a0 = 10'(12'h100 + idx0);
      a1 = 10'(12'h200 + idx1);
      drive_c0(1'b1, 1'b1, a0, 8'(8'h10 + idx0), 1'b1);
      drive_c1(1'b1, 1'b1, a1, 8'(8'h80 + idx1), 1'b1);
      cyc_check();
      total++; if (c0_if.req_ready !== ((k % 2) == 0) || c1_if.req_ready !== ((k % 2) == 1)) begin
        bad++; $display("FAIL alt_grant k=%0d got=%0b%0b exp=%0b%0b", k, c1_if.req_ready, c0_if.req_ready, (k % 2) == 1, (k % 2) == 0);
      end
      if (k > 0) begin
        total++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== exp_addr) begin
          bad++; $display("FAIL alt_port k=%0d got=%0b/%0h exp=1/%0h", k, ram_wr_en, ram_wr_addr, exp_addr);
        end
      end
      exp_addr = ((k % 2) == 1) ? a1 : a0;
      if (c0_if.req_ready === 1'b1) idx0++;
      if (c1_if.req_ready === 1'b1) idx1++;
    end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_check();
    total++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== exp_addr) begin
      bad++; $display("FAIL alt_last got=%0b/%0h exp=1/%0h", ram_wr_en, ram_wr_addr, exp_addr);
    end
    cyc_start();
    cyc_check();
    total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL alt_idle_wr_en got=%0b exp=0", ram_wr_en); end
  endtask

  task automatic test_collision();
    cyc_start();
    drive_c0(1'b1, 1'b1, 10'h010, 8'hA5, 1'b1);
    drive_c1(1'b1, 1'b0, 10'h010, 8'h00, 1'b0);
    cyc_check();
    total++; if (c0_if.req_ready !== 1'b1 || c1_if.req_ready !== 1'b0) begin
      bad++; $display("FAIL coll_stall got=%0b%0b exp=01", c1_if.req_ready, c0_if.req_ready);
    end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_check();
    total++; if (c1_if.req_ready !== 1'b1) begin bad++; $display("FAIL coll_retry got=%0b exp=1", c1_if.req_ready); end
    cyc_start();
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_check();
    total++; if (c1_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL coll_early got=%0b exp=0", c1_if.rsp_valid); end
    cyc_start();
    cyc_check();
    total++; if (c1_if.rsp_valid !== 1'b1 || c1_if.rsp_data !== 8'hA5) begin
      bad++; $display("FAIL coll_data got=%0b/%0h exp=1/a5", c1_if.rsp_valid, c1_if.rsp_data);
    end
    cyc_start();
    cyc_check();
    total++; if (c1_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL coll_once got=%0b exp=0", c1_if.rsp_valid); end
  endtask

  task automatic test_parallel();
    cyc_start();
    drive_c0(1'b1, 1'b1, 10'h030, 8'h77, 1'b1);
    drive_c1(1'b1, 1'b0, 10'h031, 8'h00, 1'b0);
    cyc_check();
    total++; if (c0_if.req_ready !== 1'b1 || c1_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL par_ready got=%0b%0b exp=11", c1_if.req_ready, c0_if.req_ready);
    end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_check();
    total++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 10'h030 || ram_wr_data !== 8'h77 || ram_rd_addr !== 10'h031) begin
      bad++; $display("FAIL par_ports got=%0b/%0h/%0h/%0h exp=1/30/77/31", ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    cyc_start();
    drive_c0(1'b1, 1'b0, 10'h030, 8'h00, 1'b0);
    cyc_check();
    total++; if (c1_if.rsp_valid !== 1'b1 || c1_if.rsp_data !== 8'hCE) begin
      bad++; $display("FAIL par_rsp1 got=%0b/%0h exp=1/ce", c1_if.rsp_valid, c1_if.rsp_data);
    end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_start();
    cyc_check();
    total++; if (c0_if.rsp_valid !== 1'b1 || c0_if.rsp_data !== 8'h77) begin
      bad++; $display("FAIL par_rsp0 got=%0b/%0h exp=1/77", c0_if.rsp_valid, c0_if.rsp_data);
    end
  endtask

  task automatic test_be_zero();
    cyc_start();
    drive_c0(1'b1, 1'b1, 10'd5, 8'h3C, 1'b1);
    cyc_start();
    drive_c0(1'b1, 1'b1, 10'd5, 8'hFF, 1'b0);
    cyc_check();
    total++; if (c0_if.req_ready !== 1'b1) begin bad++; $display("FAIL be0_ready got=%0b exp=1", c0_if.req_ready); end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_check();
    total++; if (ram_wr_en !== 1'b1 || ram_wr_byte_en !== 1'b0 || ram_wr_data !== 8'hFF) begin
      bad++; $display("FAIL be0_port got=%0b/%0h/%0h exp=1/0/ff", ram_wr_en, ram_wr_byte_en, ram_wr_data);
    end
    cyc_start();
    drive_c0(1'b1, 1'b0, 10'd5, 8'h00, 1'b0);
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    cyc_start();
    cyc_check();
    total++; if (c0_if.rsp_valid !== 1'b1 || c0_if.rsp_data !== 8'h3C) begin
      bad++; $display("FAIL be0_data got=%0b/%0h exp=1/3c", c0_if.rsp_valid, c0_if.rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    cyc_start();
    drive_c0(1'b1, 1'b1, 10'd9, 8'h55, 1'b1);
    drive_c1(1'b1, 1'b0, 10'd7, 8'h00, 1'b0);
    cyc_check();
    total++; if (c0_if.req_ready !== 1'b1 || c1_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready got=%0b%0b exp=11", c1_if.req_ready, c0_if.req_ready);
    end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    tb_wr_rst = 1'b1;
    cyc_check();
    total++; if (ram_wr_en !== 1'b0 || ram_wr_addr !== 10'd0 || ram_wr_data !== 8'd0 || ram_wr_byte_en !== 1'b0 || ram_rd_addr !== 10'd0) begin
      bad++; $display("FAIL mid_ports got=%0b/%0h/%0h/%0h/%0h exp=0/0/0/0/0", ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_byte_en, ram_rd_addr);
    end
    cyc_start();
    cyc_check();
    total++; if (c1_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_rst got=%0b exp=0", c1_if.rsp_valid); end
    cyc_start();
    tb_wr_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc_check();
      total++; if (c0_if.rsp_valid !== 1'b0 || c1_if.rsp_valid !== 1'b0) begin
        bad++; $display("FAIL mid_rsp_after k=%0d got=%0b%0b exp=00", k, c1_if.rsp_valid, c0_if.rsp_valid);
      end
      cyc_start();
    end
    drive_c0(1'b1, 1'b1, 10'h050, 8'h01, 1'b1);
    drive_c1(1'b1, 1'b1, 10'h051, 8'h02, 1'b1);
    cyc_check();
    total++; if (c0_if.req_ready !== 1'b1 || c1_if.req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_prio got=%0b%0b exp=01", c1_if.req_ready, c0_if.req_ready);
    end
    cyc_start();
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_c0(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    drive_c1(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    tb_wr_rst = 1'b1;
    test_reset();
    test_fill_and_readback();
    test_both_write();
    test_collision();
    test_parallel();
    test_be_zero();
    test_reset_mid();
    repeat (2) @(posedge wr_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
